// File: rtl/tilexy_link_sched_if.sv
// Requester-side handshake and outbound link signals for one link direction.
// The scheduler uses the master modport; the requesters and link driver use slave.
interface tilexy_link_sched_if #(
    parameter int NREQ = 3,
    parameter int W    = 729
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              link_snd;
    logic [W-1:0]      link_data;
    logic              credit_ret;
    logic              link_xoff;

    modport master (
        input  req_valid, req_data, credit_ret, link_xoff,
        output req_ready, link_snd, link_data
    );

    modport slave (
        output req_valid, req_data, credit_ret, link_xoff,
        input  req_ready, link_snd, link_data
    );
endinterface

// File: rtl/tilexy_link_sched.sv
// Credit-gated round-robin scheduler for one outbound tile X/Y link direction.
// Define TILEXY_LINK_SCHED_STATS_EN to add saturating grant and stall counters.
module tilexy_link_sched #(
    parameter int NREQ    = 3,
    parameter int W       = 729,
    parameter int CREDITS = 8,
    parameter int CW      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    tilexy_link_sched_if.master   bus,
    output logic [CW-1:0]         credit_cnt,
    output logic [1:0]            grant_idx,
    output logic                  credit_err,
    output logic [1:0]            fsm_state
`ifdef TILEXY_LINK_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0]    stat_grants,
    output logic [15:0]           stat_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        XOFF = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      rr_ptr;
    logic            can_send;
    logic            any_valid;
    logic            accept;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gnt_idx;
    logic [W-1:0]    data_p0;
    logic            vld_p1;
    logic [W-1:0]    data_p1;

    assign any_valid = |bus.req_valid;
    // Grants are suppressed while rst is high so req_ready reads 0 in the reset cycle.
    assign can_send  = !rst && (credit_cnt != '0) && !bus.link_xoff;

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        accept  = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!accept && can_send && bus.req_valid[idx]) begin
                accept   = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = 2'(idx);
            end
        end
    end

    assign data_p0       = bus.req_data[int'(gnt_idx)*W +: W];
    assign bus.req_ready = gnt;
    assign bus.link_snd  = vld_p1;
    assign bus.link_data = data_p1;

    // ---- p0 -> p1: accepted beat registered onto the link ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                data_p1   <= data_p0;
                grant_idx <= gnt_idx;
                rr_ptr    <= (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            unique case ({accept, bus.credit_ret})
                2'b10: credit_cnt <= credit_cnt - 1'b1;
                2'b01: begin
                    if (credit_cnt == CW'(CREDITS)) credit_err <= 1'b1;
                    else                            credit_cnt <= credit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!can_send)     state_nxt = XOFF;
                else if (any_valid) state_nxt = RUN;
            end
            RUN: begin
                if (!can_send)      state_nxt = XOFF;
                else if (!any_valid) state_nxt = IDLE;
            end
            XOFF: begin
                if (can_send) state_nxt = any_valid ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fsm_state = state;
    end

`ifdef TILEXY_LINK_SCHED_STATS_EN
    logic [15:0] grant_cnt [NREQ];
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && grant_cnt[i] != 16'hFFFF) grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
            if (any_valid && !can_send && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NREQ; i++) stat_grants[i*16 +: 16] = grant_cnt[i];
    end
    assign stat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_tilexy_link_sched.sv
// Directed scoreboard bench for tilexy_link_sched: accepted beats are queued and
// matched against link beats by an independent monitor.
module tb_tilexy_link_sched;
    localparam int NREQ    = 3;
    localparam int W       = 729;
    localparam int CREDITS = 8;
    localparam int CW      = 4;

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] credit_cnt;
    logic [1:0]    grant_idx;
    logic          credit_err;
    logic [1:0]    fsm_state;
`ifdef TILEXY_LINK_SCHED_STATS_EN
    logic [NREQ*16-1:0] stat_grants;
    logic [15:0]        stat_stall;
`endif

    always #5 clk = ~clk;

    tilexy_link_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    tilexy_link_sched #(.NREQ(NREQ), .W(W), .CREDITS(CREDITS), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .credit_cnt (credit_cnt),
        .grant_idx  (grant_idx),
        .credit_err (credit_err),
        .fsm_state  (fsm_state)
`ifdef TILEXY_LINK_SCHED_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_stall (stat_stall)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] mon_exp;

    function automatic logic [W-1:0] mk(int r, int n);
        logic [W-1:0] d;
        d = '0;
        d[31:0]     = 32'hC0DE_0000 | 32'(r << 8) | 32'(n);
        d[W-1 -: 32] = ~d[31:0];
        d[400 +: 16] = 16'(n * 3 + r);
        return d;
    endfunction

    task automatic set_data(int n);
        for (int r = 0; r < NREQ; r++) bus.req_data[r*W +: W] = mk(r, n);
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.link_snd === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL link_beat actual=unexpected beat required=no beat");
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.link_data !== mon_exp) begin
                    errors++;
                    $display("FAIL link_data actual=%0h required=%0h", bus.link_data, mon_exp);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.credit_ret = 1'b0;
        bus.link_xoff  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_snd",   bus.link_snd, 0);
        chk("rst_data",  64'(bus.link_data[63:0]), 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_credit", credit_cnt, 8);
        chk("rst_gidx",  grant_idx, 0);
        chk("rst_err",   credit_err, 0);
        chk("rst_state", fsm_state, 0);

        // All requesters valid: rotation 0,1,2,0,1,2
        for (int n = 0; n < 6; n++) begin
            tick();
            set_data(n);
            bus.req_valid = 3'b111;
            #1;
            chk("t1_ready", bus.req_ready, 64'(1 << (n % 3)));
            exp_q.push_back(mk(n % 3, n));
            if (n > 0) chk("t1_snd", bus.link_snd, 1);
            chk("t1_gidx", grant_idx, (n == 0) ? 0 : 64'((n - 1) % 3));
        end
        tick();
        bus.req_valid = '0;
        #1;
        chk("t1_last_snd", bus.link_snd, 1);
        chk("t1_credit", credit_cnt, 2);
        chk("t1_gidx_end", grant_idx, 2);
        chk("t1_state_run", fsm_state, 1);
        tick();
        #1;
        chk("t1_snd_off", bus.link_snd, 0);
        chk("t1_drained", exp_q.size(), 0);
        chk("t1_state_idle", fsm_state, 0);

        // Refill, then exhaust credits with requester 0 alone
        for (int k = 0; k < 6; k++) begin
            tick();
            bus.credit_ret = 1'b1;
        end
        tick();
        bus.credit_ret = 1'b0;
        #1;
        chk("t2_refill", credit_cnt, 8);
        for (int n = 0; n < 10; n++) begin
            tick();
            set_data(10 + n);
            bus.req_valid = 3'b001;
            #1;
            chk("t2_ready", bus.req_ready, (n < 8) ? 1 : 0);
            if (n < 8) exp_q.push_back(mk(0, 10 + n));
        end
        tick();
        #1;
        chk("t2_credit0", credit_cnt, 0);
        chk("t2_state_xoff", fsm_state, 2);
        chk("t2_ready_blocked", bus.req_ready, 0);
        tick();
        bus.credit_ret = 1'b1;
        #1;
        chk("t2_ret_cycle_ready", bus.req_ready, 0);
        tick();
        bus.credit_ret = 1'b0;
        set_data(30);
        #1;
        chk("t2_one_grant", bus.req_ready, 1);
        chk("t2_credit1", credit_cnt, 1);
        exp_q.push_back(mk(0, 30));
        tick();
        #1;
        chk("t2_after_last", bus.req_ready, 0);
        chk("t2_credit_end", credit_cnt, 0);
        chk("t2_snd", bus.link_snd, 1);
        tick();
        bus.req_valid = '0;

        // Simultaneous accept and credit return at 3 credits
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.credit_ret = 1'b1;
        end
        tick();
        bus.credit_ret = 1'b1;
        bus.req_valid  = 3'b010;
        set_data(40);
        #1;
        chk("t3_pre_credit", credit_cnt, 3);
        chk("t3_ready", bus.req_ready, 3'b010);
        exp_q.push_back(mk(1, 40));
        tick();
        bus.credit_ret = 1'b0;
        bus.req_valid  = '0;
        #1;
        chk("t3_credit_same", credit_cnt, 3);

        // Overflow saturates and sets the sticky error
        for (int k = 0; k < 5; k++) begin
            tick();
            bus.credit_ret = 1'b1;
        end
        tick();
        bus.credit_ret = 1'b0;
        #1;
        chk("t4_full", credit_cnt, 8);
        chk("t4_err_clear", credit_err, 0);
        tick();
        bus.credit_ret = 1'b1;
        tick();
        bus.credit_ret = 1'b0;
        #1;
        chk("t4_sat", credit_cnt, 8);
        chk("t4_err_set", credit_err, 1);
        repeat (3) tick();
        chk("t4_err_sticky", credit_err, 1);

        // xoff window blocks requester 1; release grants it the same cycle
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.link_xoff = 1'b1;
            bus.req_valid = 3'b010;
            set_data(50);
            #1;
            chk("t5_xoff_ready", bus.req_ready, 0);
        end
        chk("t5_state_xoff", fsm_state, 2);
        tick();
        bus.link_xoff = 1'b0;
        set_data(51);
        #1;
        chk("t5_release", bus.req_ready, 3'b010);
        exp_q.push_back(mk(1, 51));
        tick();
        bus.req_valid = '0;
        #1;
        chk("t5_snd", bus.link_snd, 1);
        chk("t5_gidx", grant_idx, 1);
`ifdef TILEXY_LINK_SCHED_STATS_EN
        chk("stat_g0", stat_grants[15:0], 11);
        chk("stat_g1", stat_grants[31:16], 4);
        chk("stat_g2", stat_grants[47:32], 2);
`endif

        // Reset right after an accept
        tick();
        bus.req_valid = 3'b100;
        set_data(60);
        #1;
        chk("t6_ready", bus.req_ready, 3'b100);
        exp_q.push_back(mk(2, 60));
        tick();
        rst = 1'b1;
        #1;
        chk("t6_ready_in_rst", bus.req_ready, 0);
        chk("t6_snd_before", bus.link_snd, 1);
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("t6_snd", bus.link_snd, 0);
        chk("t6_credit", credit_cnt, 8);
        chk("t6_gidx", grant_idx, 0);
        chk("t6_err", credit_err, 0);
        chk("t6_state", fsm_state, 0);
        chk("t6_data", 64'(bus.link_data[63:0]), 0);
`ifdef TILEXY_LINK_SCHED_STATS_EN
        chk("t6_stat_grants", 64'(stat_grants), 0);
        chk("t6_stat_stall", stat_stall, 0);
`endif
        tick();
        #1;
        chk("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
